// File: rtl/mux_layer_rr.sv
// Bank of LANES registered RATIO:1 multiplexers with external or round-robin selection.
// Optional drop counter output (drop_cnt) is built only when MUX_STATUS_EN is defined.
module mux_layer_rr #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int RATIO = 2,
  parameter int SEL_W = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LANES*RATIO*WIDTH-1:0]   in_data,
  input  logic [LANES*RATIO-1:0]         in_valid,
  input  logic [SEL_W-1:0]               sel_ext,
  input  logic                           sel_mode,
  input  logic                           enable,
  output logic [LANES*WIDTH-1:0]         out_data,
  output logic [LANES-1:0]               out_valid,
  output logic [SEL_W-1:0]               sel_cur
`ifdef MUX_STATUS_EN
  ,
  output logic [7:0]                     drop_cnt
`endif
);

  // Handshake: valid-only, no ready. A word is transferred when its lane's
  // selected in_valid is 1 on an enabled edge; unselected valid words are lost.
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] pick_data [LANES];
  logic [LANES-1:0] pick_valid;

  always_comb begin
    sel        = sel_mode ? sel_cur : sel_ext;
    pick_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      pick_data[l] = '0;
      for (int k = 0; k < RATIO; k++) begin
        if (SEL_W'(k) == sel) begin
          pick_valid[l] = in_valid[l*RATIO+k];
          pick_data[l]  = in_data[(l*RATIO+k)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Data holds when the selected input is not valid; valid always follows.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= '0;
      sel_cur   <= '0;
    end else if (enable) begin
      out_valid <= pick_valid;
      for (int l = 0; l < LANES; l++) begin
        if (pick_valid[l]) out_data[l*WIDTH +: WIDTH] <= pick_data[l];
      end
      if (sel_mode) sel_cur <= sel_cur + SEL_W'(1);
    end
  end

`ifdef MUX_STATUS_EN
  logic drop_any;

  always_comb begin
    drop_any = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < RATIO; k++) begin
        if ((SEL_W'(k) != sel) && in_valid[l*RATIO+k]) drop_any = 1'b1;
      end
    end
  end

  // One count per cycle with any drop, saturating at 255.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (enable && drop_any && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_layer_rr.sv
// Self-checking bench for mux_layer_rr: default instance (8b, 2 lanes, 2:1) plus a 16b, 3-lane, 4:1 instance.
module tb_mux_layer_rr;
  localparam int W  = 8;
  localparam int L  = 2;
  localparam int R  = 2;
  localparam int S  = 1;
  localparam int BW = 16;
  localparam int BL = 3;
  localparam int BR = 4;
  localparam int BS = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic                 a_reset;
  logic [L*R*W-1:0]     a_in_data;
  logic [L*R-1:0]       a_in_valid;
  logic [S-1:0]         a_sel_ext;
  logic                 a_sel_mode;
  logic                 a_enable;
  logic [L*W-1:0]       a_out_data;
  logic [L-1:0]         a_out_valid;
  logic [S-1:0]         a_sel_cur;
`ifdef MUX_STATUS_EN
  logic [7:0]           a_drop_cnt;
`endif

  logic                 b_reset;
  logic [BL*BR*BW-1:0]  b_in_data;
  logic [BL*BR-1:0]     b_in_valid;
  logic [BS-1:0]        b_sel_ext;
  logic                 b_sel_mode;
  logic                 b_enable;
  logic [BL*BW-1:0]     b_out_data;
  logic [BL-1:0]        b_out_valid;
  logic [BS-1:0]        b_sel_cur;
`ifdef MUX_STATUS_EN
  logic [7:0]           b_drop_cnt;
`endif

  mux_layer_rr #(.WIDTH(W), .LANES(L), .RATIO(R), .SEL_W(S)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .sel_ext(a_sel_ext), .sel_mode(a_sel_mode), .enable(a_enable),
    .out_data(a_out_data), .out_valid(a_out_valid), .sel_cur(a_sel_cur)
`ifdef MUX_STATUS_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  mux_layer_rr #(.WIDTH(BW), .LANES(BL), .RATIO(BR), .SEL_W(BS)) dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .sel_ext(b_sel_ext), .sel_mode(b_sel_mode), .enable(b_enable),
    .out_data(b_out_data), .out_valid(b_out_valid), .sel_cur(b_sel_cur)
`ifdef MUX_STATUS_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  // reference model of instance A: what each lane should hold after the edge
  logic [W-1:0] m_data [L];
  logic [L-1:0] m_valid;
  int           m_sel;
  int           m_drop;
  logic [L*W-1:0] exp_q [$];

  function automatic logic [L*W-1:0] m_flat();
    logic [L*W-1:0] r;
    for (int l = 0; l < L; l++) r[l*W +: W] = m_data[l];
    return r;
  endfunction

  // driver: apply inputs, advance the model, step one edge, settle 1 time unit
  task automatic drive_a(input logic rst, input logic en, input logic mode, input int sx,
                         input logic [L*R*W-1:0] d, input logic [L*R-1:0] v);
    int s;
    bit drop;
    a_reset    = rst;
    a_enable   = en;
    a_sel_mode = mode;
    a_sel_ext  = S'(sx);
    a_in_data  = d;
    a_in_valid = v;
    if (!rst) begin
      for (int l = 0; l < L; l++) m_data[l] = '0;
      m_valid = '0;
      m_sel   = 0;
      m_drop  = 0;
    end else if (en) begin
      s    = mode ? m_sel : (sx % R);
      drop = 1'b0;
      for (int l = 0; l < L; l++) begin
        m_valid[l] = v[l*R+s];
        if (v[l*R+s]) m_data[l] = d[(l*R+s)*W +: W];
        for (int k = 0; k < R; k++) if (k != s && v[l*R+k]) drop = 1'b1;
      end
      if (drop && m_drop < 255) m_drop++;
      if (mode) m_sel = (m_sel + 1) % R;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b0, 1'b1, 1'b0, 0, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 4'hF);
      n_tests++;
      if (a_out_data !== 16'h0000) begin
        n_fail++; $display("FAIL reset_data cycle=%0d actual=%h expected=0000", i, a_out_data);
      end
      n_tests++;
      if (a_out_valid !== 2'b00 || a_sel_cur !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid_sel actual=%b/%b expected=00/0", a_out_valid, a_sel_cur);
      end
    end
    drive_a(1'b1, 1'b1, 1'b0, 0, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 4'hF);
    n_tests++;
    if (a_out_data !== 16'hCCAA || a_out_valid !== 2'b11) begin
      n_fail++; $display("FAIL reset_release actual=%h/%b expected=ccaa/11", a_out_data, a_out_valid);
    end
  endtask

  task automatic test_ext_select();
    int         sels [4] = '{0, 1, 1, 0};
    logic [7:0] e0   [4] = '{8'h11, 8'h22, 8'h22, 8'h11};
    logic [7:0] e1   [4] = '{8'h33, 8'h44, 8'h44, 8'h33};
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, sels[i], {8'h44, 8'h33, 8'h22, 8'h11}, 4'hF);
      n_tests++;
      if (a_out_data !== {e1[i], e0[i]} || a_out_valid !== 2'b11) begin
        n_fail++;
        $display("FAIL ext_select step=%0d actual=%h/%b expected=%h%h/11", i, a_out_data, a_out_valid, e1[i], e0[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [L*R*W-1:0] d;
    logic [L*W-1:0]   snap_d;
    logic [L-1:0]     snap_v;
    logic [S-1:0]     snap_s;
    drive_a(1'b0, 1'b1, 1'b1, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom} >> 32;
      drive_a(1'b1, 1'b1, 1'b1, $urandom_range(0, 1), d, 4'hF);
      n_tests++;
      if (a_sel_cur !== S'((i + 1) % 2)) begin
        n_fail++; $display("FAIL rr_sel step=%0d actual=%0d expected=%0d", i, a_sel_cur, (i + 1) % 2);
      end
      n_tests++;
      if (a_out_data[W-1:0] !== d[(i % 2)*W +: W] || a_out_data !== m_flat()) begin
        n_fail++; $display("FAIL rr_data step=%0d actual=%h expected=%h", i, a_out_data, m_flat());
      end
    end
    snap_d = a_out_data;
    snap_v = a_out_valid;
    snap_s = a_sel_cur;
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b1, 1'b0, 1'b1, $urandom_range(0, 1), L*R*W'($urandom), 4'($urandom));
      n_tests++;
      if (a_out_data !== snap_d || a_out_valid !== snap_v || a_sel_cur !== snap_s) begin
        n_fail++;
        $display("FAIL enable_hold step=%0d actual=%h/%b/%0d expected=%h/%b/%0d",
                 i, a_out_data, a_out_valid, a_sel_cur, snap_d, snap_v, snap_s);
      end
    end
  endtask

  task automatic test_hold_invalid();
    drive_a(1'b1, 1'b1, 1'b0, 1, {8'h44, 8'h33, 8'h22, 8'h11}, 4'hF);
    n_tests++;
    if (a_out_data[7:0] !== 8'h22) begin
      n_fail++; $display("FAIL hold_setup actual=%h expected=22", a_out_data[7:0]);
    end
    drive_a(1'b1, 1'b1, 1'b0, 1, {8'h44, 8'h33, 8'h5A, 8'h11}, 4'b1101);
    n_tests++;
    if (a_out_valid !== 2'b10 || a_out_data[7:0] !== 8'h22) begin
      n_fail++; $display("FAIL hold_invalid actual=%b/%h expected=10/22", a_out_valid, a_out_data[7:0]);
    end
    drive_a(1'b1, 1'b1, 1'b0, 1, {8'h44, 8'h33, 8'h5A, 8'h11}, 4'hF);
    n_tests++;
    if (a_out_valid !== 2'b11 || a_out_data[7:0] !== 8'h5A) begin
      n_fail++; $display("FAIL hold_recover actual=%b/%h expected=11/5a", a_out_valid, a_out_data[7:0]);
    end
  endtask

  task automatic test_random();
    logic [L*W-1:0] exp_d;
    for (int i = 0; i < 300; i++) begin
      drive_a(logic'($urandom_range(0, 31) != 0), logic'($urandom_range(0, 3) != 0),
              logic'($urandom_range(0, 1)), $urandom_range(0, 1),
              L*R*W'($urandom), 4'($urandom));
      exp_q.push_back(m_flat());
      exp_d = exp_q.pop_front();
      n_tests++;
      if (a_out_data !== exp_d || a_out_valid !== m_valid || a_sel_cur !== S'(m_sel)) begin
        n_fail++;
        $display("FAIL random step=%0d actual=%h/%b/%0d expected=%h/%b/%0d",
                 i, a_out_data, a_out_valid, a_sel_cur, exp_d, m_valid, m_sel);
      end
`ifdef MUX_STATUS_EN
      n_tests++;
      if (a_drop_cnt !== 8'(m_drop)) begin
        n_fail++; $display("FAIL random_drop step=%0d actual=%0d expected=%0d", i, a_drop_cnt, m_drop);
      end
`endif
    end
  endtask

  task automatic test_ratio4();
    logic [BL*BR*BW-1:0] d;
    b_reset = 1'b0; b_enable = 1'b1; b_sel_mode = 1'b1; b_sel_ext = '0;
    b_in_valid = '1; b_in_data = '0;
    @(posedge clk); #1;
    n_tests++;
    if (b_sel_cur !== 2'd0 || b_out_valid !== 3'b000) begin
      n_fail++; $display("FAIL r4_reset actual=%0d/%b expected=0/000", b_sel_cur, b_out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < BL*BR; w++) d[w*BW +: BW] = BW'($urandom);
      b_reset = 1'b1; b_in_data = d; b_sel_ext = BS'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (b_sel_cur !== BS'((i + 1) % 4)) begin
        n_fail++; $display("FAIL r4_sel step=%0d actual=%0d expected=%0d", i, b_sel_cur, (i + 1) % 4);
      end
      n_tests++;
      if (b_out_data[2*BW +: BW] !== d[(8 + i % 4)*BW +: BW] || b_out_valid !== 3'b111) begin
        n_fail++;
        $display("FAIL r4_lane2 step=%0d actual=%h expected=%h", i, b_out_data[2*BW +: BW], d[(8 + i % 4)*BW +: BW]);
      end
    end
  endtask

`ifdef MUX_STATUS_EN
  task automatic test_drop_sat();
    drive_a(1'b0, 1'b1, 1'b0, 0, '0, '0);
    for (int i = 0; i < 300; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 0, L*R*W'($urandom), 4'hF);
      n_tests++;
      if (a_drop_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
        n_fail++; $display("FAIL drop_sat step=%0d actual=%0d", i, a_drop_cnt);
      end
    end
    drive_a(1'b0, 1'b1, 1'b0, 0, '0, 4'hF);
    n_tests++;
    if (a_drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL drop_reset actual=%0d expected=0", a_drop_cnt);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    a_reset = 1'b0; a_enable = 1'b0; a_sel_mode = 1'b0; a_sel_ext = '0;
    a_in_data = '0; a_in_valid = '0;
    b_reset = 1'b0; b_enable = 1'b0; b_sel_mode = 1'b0; b_sel_ext = '0;
    b_in_data = '0; b_in_valid = '0;
    for (int l = 0; l < L; l++) m_data[l] = '0;
    m_valid = '0; m_sel = 0; m_drop = 0;
    test_reset();
    test_ext_select();
    test_round_robin();
    test_hold_invalid();
    test_random();
    test_ratio4();
`ifdef MUX_STATUS_EN
    test_drop_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
